// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
//
// Round-robin arbiter and access sequencer placed in front of the single-port
// data memory. Port 0 is the CPU load/store unit; port 1 is the program
// loader/debug port. Every access runs through IDLE -> ACCESS -> RESP.
// Misaligned word accesses skip ACCESS, so the memory is never touched.
//
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   mN_req                 request, held high by the requester until mN_ack
//   mN_we                  1 = store, 0 = load
//   mN_addr, mN_wdata      byte address and store data, sampled at grant
//   mN_ack                 one-cycle completion pulse
//   mN_err                 misaligned-address flag, valid with mN_ack
//   mN_rdata               last load data captured for port N
//   MemRead, MemWrite      memory strobes, asserted only in ACCESS
//   mem_addr, mem_wdata    memory address and write data (latched request)
//   mem_rdata              combinational memory read data
//   busy                   high whenever the sequencer is not in IDLE
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,

    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Transaction latched at grant; later input changes are ignored.
    logic              owner_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    // Port that won the previous grant; the other port wins a tie.
    logic              last_owner_q;

    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

    // Arbitration for the current IDLE cycle.
    logic              grant;
    logic              grant_port;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_misaligned;

    always_comb begin
        grant = m0_req | m1_req;
        if (m0_req && m1_req) begin
            grant_port = ~last_owner_q;
        end else begin
            // A lone m1 request selects 1; a lone m0 request (or none) selects 0.
            grant_port = m1_req;
        end
    end

    assign sel_we         = grant_port ? m1_we    : m0_we;
    assign sel_addr       = grant_port ? m1_addr  : m0_addr;
    assign sel_wdata      = grant_port ? m1_wdata : m0_wdata;
    assign sel_misaligned = |sel_addr[1:0];

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe/handshake decode; all outputs depend on state only,
    // so reset drops them immediately without waiting for a clock edge.
    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        m0_ack   = 1'b0;
        m0_err   = 1'b0;
        m1_ack   = 1'b0;
        m1_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = sel_misaligned ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                MemRead  = ~we_q;
                MemWrite = we_q;
                state_d  = RESP;
            end
            RESP: begin
                m0_ack  = ~owner_q;
                m0_err  = ~owner_q & err_q;
                m1_ack  = owner_q;
                m1_err  = owner_q & err_q;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request latch, round-robin history and per-port load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_owner_q <= 1'b1;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            if (state_q == IDLE && grant) begin
                owner_q      <= grant_port;
                we_q         <= sel_we;
                err_q        <= sel_misaligned;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
                last_owner_q <= grant_port;
            end
            // Loads capture at the end of ACCESS; stores and errors leave
            // the owner's rdata untouched.
            if (state_q == ACCESS && !we_q) begin
                if (owner_q) begin
                    rdata1_q <= mem_rdata;
                end else begin
                    rdata0_q <= mem_rdata;
                end
            end
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
//
// Self-checking bench for data_mem_arbiter: a 16-word memory model sits on
// the memory side, a table of single transactions plus hand-written
// multi-cycle sequences cover the directed cases, and a randomized phase is
// checked cycle by cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;

    logic              m0_req, m0_we, m0_ack, m0_err;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata, m0_rdata;
    logic              m1_req, m1_we, m1_ack, m1_err;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata, m1_rdata;
    logic              MemRead, MemWrite, busy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // ---------------- memory model ----------------
    logic [DATA_W-1:0] mem [16];
    logic              mem_load;

    function automatic logic [DATA_W-1:0] init_val(input int i);
        if (i == 0)      return 32'd10;
        else if (i == 1) return 32'd1;
        else             return 32'h1000_0000 + 32'(i);
    endfunction

    assign mem_rdata = MemRead ? mem[mem_addr[5:2]] : '0;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
        end else if (MemWrite) begin
            mem[mem_addr[5:2]] <= mem_wdata;
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic set_port(input bit p, input logic req, input logic we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
        if (p) begin
            m1_req = req; m1_we = we; m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_addr = a; m0_wdata = wd;
        end
    endtask

    function automatic logic [6:0] ctrl_vec();
        return {busy, m0_ack, m0_err, m1_ack, m1_err, MemRead, MemWrite};
    endfunction

    // One transaction from an IDLE cycle up to its ack, with strobe monitoring.
    task automatic run_txn(input bit p, input bit we, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] wd,
                           output int lat, output bit err, output logic [DATA_W-1:0] rd,
                           output int nrd, output int nwr, output int nother,
                           output logic [ADDR_W-1:0] saddr);
        int  cyc;
        bit  done;
        nrd = 0; nwr = 0; nother = 0; saddr = '0; err = 1'b0; done = 1'b0;
        @(negedge clk);
        set_port(p, 1'b1, we, a, wd);
        cyc = 1;
        while (!done && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (MemRead)  nrd++;
            if (MemWrite) nwr++;
            if (MemRead || MemWrite) saddr = mem_addr;
            if (p ? m0_ack : m1_ack) nother++;
            if (p ? m1_ack : m0_ack) begin
                done = 1'b1;
                err  = p ? m1_err : m0_err;
            end
        end
        lat = done ? cyc : 0;
        rd  = p ? m1_rdata : m0_rdata;
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        bit                port;
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        bit                exp_err;
        int                exp_lat;
        int                exp_nrd;
        int                exp_nwr;
        logic [DATA_W-1:0] exp_rdata;
    } vec_t;

    vec_t vecs[10];

    // ---------------- reference model state (random phase) ----------------
    bit                act, own, mwe, mis, last;
    int                age, len;
    logic [ADDR_W-1:0] maddr;
    logic [DATA_W-1:0] mwdata;
    logic [DATA_W-1:0] rd_ref [2];
    logic [DATA_W-1:0] ref_mem [16];
    bit                pend [2];
    bit                e_busy, e_ack0, e_ack1, e_err, e_rd, e_wr;

    initial begin
        int                lat, nrd, nwr, nother;
        bit                err;
        logic [DATA_W-1:0] rd;
        logic [ADDR_W-1:0] saddr;
        logic [ADDR_W-1:0] ra;

        vecs[0] = '{0, 1, 6'd8,  32'hDEADBEEF, 0, 3, 0, 1, 32'd10};
        vecs[1] = '{0, 0, 6'd8,  32'h0,        0, 3, 1, 0, 32'hDEADBEEF};
        vecs[2] = '{1, 1, 6'd6,  32'hBAD0BAD0, 1, 2, 0, 0, 32'd1};
        vecs[3] = '{1, 0, 6'd8,  32'h0,        0, 3, 1, 0, 32'hDEADBEEF};
        vecs[4] = '{1, 0, 6'd4,  32'h0,        0, 3, 1, 0, 32'd1};
        vecs[5] = '{1, 1, 6'h3C, 32'h12345678, 0, 3, 0, 1, 32'd1};
        vecs[6] = '{0, 0, 6'h3C, 32'h0,        0, 3, 1, 0, 32'h12345678};
        vecs[7] = '{0, 0, 6'd1,  32'h0,        1, 2, 0, 0, 32'h12345678};
        vecs[8] = '{1, 0, 6'h3F, 32'h0,        1, 2, 0, 0, 32'd1};
        vecs[9] = '{0, 1, 6'h22, 32'hFFFF0000, 1, 2, 0, 0, 32'h12345678};

        // Reset with both ports already requesting: m0 load 0, m1 load 4.
        rst = 1'b1;
        mem_load = 1'b1;
        set_port(0, 1'b1, 1'b0, 6'd0, '0);
        set_port(1, 1'b1, 1'b0, 6'd4, '0);
        @(negedge clk);
        @(negedge clk);
        check("rst_ctrl",  64'(ctrl_vec()), 64'd0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        check("rst_bus",   64'({mem_addr, mem_wdata}), 64'd0);
        rst = 1'b0;
        mem_load = 1'b0;

        // Round robin under permanent contention: m0, m1, m0 with acks at 3, 6, 9.
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            check("rr_busy_ack", 64'({busy, m0_ack, m1_ack}),
                  64'({c % 3 != 1, c == 3 || c == 9, c == 6}));
            if (c == 3) check("rr_m0_rdata", 64'(m0_rdata), 64'd10);
            if (c == 6) check("rr_m1_rdata", 64'(m1_rdata), 64'd1);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Table-driven single transactions.
        for (int i = 0; i < 10; i++) begin
            run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                    lat, err, rd, nrd, nwr, nother, saddr);
            check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d_err", i), 64'(err), 64'(vecs[i].exp_err));
            check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].exp_rdata));
            check($sformatf("vec%0d_strobes", i), 64'({nrd[7:0], nwr[7:0]}),
                  64'({vecs[i].exp_nrd[7:0], vecs[i].exp_nwr[7:0]}));
            check($sformatf("vec%0d_other_ack", i), 64'(nother), 64'd0);
            if (vecs[i].exp_nrd + vecs[i].exp_nwr > 0)
                check($sformatf("vec%0d_mem_addr", i), 64'(saddr), 64'(vecs[i].addr));
        end
        check("mem_word4_unchanged", 64'(mem[1]), 64'd1);

        // Back-to-back m0 loads with req held across each ack; address changes
        // at each ack so every transaction returns distinct data.
        @(negedge clk);
        set_port(0, 1'b1, 1'b0, 6'd8, '0);
        for (int c = 2; c <= 9; c++) begin
            @(negedge clk);
            check("b2b_busy_ack", 64'({busy, m0_ack, m1_ack}),
                  64'({c % 3 != 1, c % 3 == 0, 1'b0}));
            if (c == 3) begin
                check("b2b_rdata0", 64'(m0_rdata), 64'hDEADBEEF);
                m0_addr = 6'd4;
            end
            if (c == 6) begin
                check("b2b_rdata1", 64'(m0_rdata), 64'd1);
                m0_addr = 6'h3C;
            end
            if (c == 9) check("b2b_rdata2", 64'(m0_rdata), 64'h12345678);
        end
        set_port(0, 1'b0, 1'b0, '0, '0);

        // Reset asserted in the middle of an m1 store's ACCESS cycle.
        @(negedge clk);
        set_port(1, 1'b1, 1'b1, 6'd12, 32'hCAFEF00D);
        @(negedge clk);
        check("rsta_access", 64'({MemWrite, busy, mem_addr}), 64'({1'b1, 1'b1, 6'd12}));
        #1;
        rst = 1'b1;
        set_port(0, 1'b1, 1'b0, 6'd0, '0);
        set_port(1, 1'b1, 1'b0, 6'd4, '0);
        #1;
        check("rsta_async_drop", 64'({MemWrite, MemRead, busy, m0_ack, m1_ack}), 64'd0);
        @(negedge clk);
        check("rsta_held", 64'(ctrl_vec()), 64'd0);
        rst = 1'b0;
        for (int c = 2; c <= 3; c++) begin
            @(negedge clk);
            check("rsta_first_grant", 64'({m0_ack, m1_ack}), 64'({c == 3, 1'b0}));
        end
        check("rsta_m0_rdata", 64'(m0_rdata), 64'd10);
        set_port(0, 1'b0, 1'b0, '0, '0);
        set_port(1, 1'b0, 1'b0, '0, '0);

        // Both ports idle: nothing moves and rdata holds.
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("idle_ctrl", 64'(ctrl_vec()), 64'd0);
            check("idle_rdata", {m0_rdata, m1_rdata}, {32'd10, 32'd0});
        end

        // Randomized traffic against the transaction-level model.
        @(negedge clk);
        rst = 1'b1;
        mem_load = 1'b1;
        @(negedge clk);
        check("rnd_rst_ctrl", 64'(ctrl_vec()), 64'd0);
        check("rnd_rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
        rst = 1'b0;
        mem_load = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
        act = 0; last = 1; age = 0; len = 0;
        rd_ref[0] = '0; rd_ref[1] = '0;
        pend[0] = 0; pend[1] = 0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            // Expected outputs for this cycle from the transaction's position.
            e_busy = act && age > 0;
            e_ack0 = act && age == len - 1 && !own;
            e_ack1 = act && age == len - 1 && own;
            e_err  = mis;
            e_rd   = act && !mis && age == 1 && !mwe;
            e_wr   = act && !mis && age == 1 && mwe;
            check("rnd_ctrl", 64'(ctrl_vec()),
                  64'({e_busy, e_ack0, e_ack0 & e_err, e_ack1, e_ack1 & e_err, e_rd, e_wr}));
            if (e_rd || e_wr) check("rnd_mem_addr", 64'(mem_addr), 64'(maddr));
            if (e_wr) check("rnd_mem_wdata", 64'(mem_wdata), 64'(mwdata));
            check("rnd_rdata", {m0_rdata, m1_rdata}, {rd_ref[0], rd_ref[1]});

            // Effects of the edge that ends this cycle.
            if (e_rd) rd_ref[own] = ref_mem[maddr[5:2]];
            if (e_wr) ref_mem[maddr[5:2]] = mwdata;
            if (e_ack0) pend[0] = 0;
            if (e_ack1) pend[1] = 0;

            // Requester behaviour.
            for (int p = 0; p < 2; p++) begin
                ra = 6'($urandom_range(0, 63));
                if ($urandom_range(0, 4) != 0) ra[1:0] = 2'b00;
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) != 0) begin
                        pend[p] = 1;
                        set_port(p[0], 1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
                    end else begin
                        set_port(p[0], 1'b0, 1'($urandom_range(0, 1)), ra, $urandom);
                    end
                end else if (act && own == p[0]) begin
                    // Already granted: inputs other than req are don't-care now.
                    set_port(p[0], 1'b1, 1'($urandom_range(0, 1)), ra, $urandom);
                end
            end

            // Advance the model to the next cycle.
            if (act) begin
                age++;
                if (age == len) act = 0;
            end else if (m0_req || m1_req) begin
                if (m0_req && m1_req) own = (last == 1'b1) ? 1'b0 : 1'b1;
                else                  own = m1_req;
                last   = own;
                mwe    = own ? m1_we    : m0_we;
                maddr  = own ? m1_addr  : m0_addr;
                mwdata = own ? m1_wdata : m0_wdata;
                mis    = (maddr % 4) != 0;
                len    = mis ? 2 : 3;
                age    = 1;
                act    = 1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the single-port data memory (byte address, word-indexed, combinational read, write on posedge clk).
- Lets the CPU load/store unit (port 0) and the program loader/debug port (port 1) share the one memory.
- Sequences each access through a fixed 3-state transaction.
- Rejects misaligned word accesses without touching memory.

Parameters:
ADDR_W, 6, byte address width on requester and memory sides
DATA_W, 32, data word width

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
m0_req  in  1  port 0 request; held high until m0_ack
m0_we  in  1  port 0 write enable (1 = store, 0 = load)
m0_addr  in  ADDR_W  port 0 byte address
m0_wdata  in  DATA_W  port 0 store data
m0_ack  out  1  port 0 one-cycle completion pulse
m0_err  out  1  port 0 misaligned flag, valid with m0_ack
m0_rdata  out  DATA_W  port 0 load data, valid with m0_ack
m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata  same as port 0, for port 1
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data (combinational, zero when MemRead low)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All acks, errs, MemRead, MemWrite and busy = 0.
  - rdata registers, mem_addr and mem_wdata = 0.
  - last_owner = 1, so port 0 wins the first contention.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If no req is high, stay in IDLE.
  - If exactly one req is high, grant that port.
  - If both reqs are high, grant the port != last_owner.
  - On grant, latch owner, we, addr, wdata and update last_owner.
  - If latched addr[1:0] == 0, go to ACCESS.
  - If latched addr[1:0] != 0, go to RESP with err pending; no memory strobe is ever asserted.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata are driven from the latched values.
  - MemWrite = we and MemRead = !we; both are combinational from state.
  - Loads capture mem_rdata into the owner's rdata register at the cycle end.
  - The write commits at the same edge.
  - Next state = RESP.
- RESP (one cycle):
  - Owner's ack = 1; owner's err = 1 only if misaligned.
  - The non-owner's outputs stay 0.
  - Next state = IDLE.
- Outputs:
  - Strobes are 0 outside ACCESS.
  - rdata holds its last captured value until the next load for that port; stores and errors leave it unchanged.
- Latency: aligned access = 3 cycles from sampled req to ack-end (IDLE, ACCESS, RESP); misaligned = 2 cycles.
- Requester rule: req must drop, or carry a new request, at the edge ending its ack cycle. A req still high in the following IDLE is treated as a new request.
- The addr/we/wdata inputs are sampled only at grant; later changes while busy are ignored.
- The waiting port keeps its req high and is served on the next IDLE. Round-robin bounds its wait to one transaction.
- Reset during ACCESS: strobes drop immediately. No ack is issued. A write in progress may or may not commit; the bench does not check memory content after reset in this case.
- rst release: the first grant is possible on the first rising edge with rst low.

Test Plan:
- m0 store: m0_req=1, we=1, addr=8, wdata=0xDEADBEEF. Then m0 load from addr 8. Required: MemWrite high for one cycle with mem_addr=8; load m0_ack 3 cycles after req with m0_rdata=0xDEADBEEF and m0_err=0.
- Both reqs high from reset, m0 load addr 0, m1 load addr 4 (memory preloaded 10, 1). Required: m0 acked first with rdata=10; m1 acked 3 cycles later with rdata=1; then with both held again, m0 served next.
- m1 store to addr 6 (misaligned). Required: m1_ack and m1_err high in the 2nd cycle; MemRead and MemWrite never asserted; word at addr 4 unchanged.
- Back-to-back m0 loads with req held continuously across ack. Required: a new transaction every 3 cycles; busy low only in the IDLE cycles.
- Assert rst during ACCESS of an m1 store. Required: MemWrite and busy drop in the same cycle without a clock edge; no ack; after release an m0 request is granted first.
- Both ports idle for 10 cycles. Required: busy, strobes and acks stay 0; rdata outputs hold their previous values.
